// File: rtl/nn_pkg.sv
// Shared fixed-point constants, FSM state type and activation helper for the MLP datapath.
// All samples, weights and activations are signed Q5.15 in DATA_W bits.
package nn_pkg;

    localparam int DATA_W = 20;
    localparam int FRAC_W = 15;
    localparam int PROD_W = 2 * DATA_W;

    localparam logic signed [DATA_W-1:0] Q_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] Q_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        MAC  = 2'd1,
        ACT  = 2'd2,
        OUT  = 2'd3
    } state_t;

    function automatic logic signed [DATA_W-1:0] relu(input logic signed [DATA_W-1:0] v);
        return v[DATA_W-1] ? '0 : v;
    endfunction

endpackage

// File: rtl/hidden_layer_mac_if.sv
// Bus bundle of hidden_layer_mac: coefficient write port, input sample stream,
// activation result stream and busy flag. slave = the MAC block, master = its driver.
interface hidden_layer_mac_if #(
    parameter int N_IN = 2,
    parameter int AW   = $clog2(2 * N_IN + 2)
);

    logic                               cfg_we;
    logic [AW-1:0]                      cfg_addr;
    logic signed [nn_pkg::DATA_W-1:0]   cfg_wdata;

    logic                               x_valid;
    logic                               x_ready;
    logic signed [nn_pkg::DATA_W-1:0]   x_data;

    logic                               out_valid;
    logic                               out_ready;
    logic signed [nn_pkg::DATA_W-1:0]   N1_1;
    logic signed [nn_pkg::DATA_W-1:0]   N1_2;

    logic                               busy;

    modport slave (
        input  cfg_we, cfg_addr, cfg_wdata,
        input  x_valid, x_data, out_ready,
        output x_ready, out_valid, N1_1, N1_2, busy
    );

    modport master (
        output cfg_we, cfg_addr, cfg_wdata,
        output x_valid, x_data, out_ready,
        input  x_ready, out_valid, N1_1, N1_2, busy
    );

endinterface

// File: rtl/nn_mac_unit.sv
// Single shared multiplier with two accumulators: acc_sel picks which neuron the
// floored Q5.15 product is added to; load preloads both accumulators with their biases.
module nn_mac_unit
    import nn_pkg::*;
#(
    parameter int ACC_W = 28
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     load,
    input  logic signed [ACC_W-1:0]  load1,
    input  logic signed [ACC_W-1:0]  load2,
    input  logic                     en,
    input  logic                     acc_sel,
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    output logic signed [ACC_W-1:0]  acc1,
    output logic signed [ACC_W-1:0]  acc2
);

    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  term;

    // The arithmetic shift floors toward -inf; only 25 significant bits survive it.
    assign prod = a * b;
    assign term = ACC_W'(prod >>> FRAC_W);

    // NOTE: sequential state is updated with non-blocking assignments only, so every
    // register samples values from before the edge regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc1 <= '0;
            acc2 <= '0;
        end else if (load) begin
            acc1 <= load1;
            acc2 <= load2;
        end else if (en) begin
            if (acc_sel) acc2 <= acc2 + term;
            else         acc1 <= acc1 + term;
        end
    end

endmodule

// File: rtl/hidden_layer_mac.sv
// Hidden layer of the MLP: collects N_IN samples, runs bias + sum(x*w) for two neurons
// on one shared multiplier, applies ReLU. Define HIDDEN_SAT_EN to saturate instead of wrap.
module hidden_layer_mac
    import nn_pkg::*;
#(
    parameter int N_IN  = 2,
    parameter int ACC_W = 28
) (
    input  logic               clk,
    input  logic               rst_n,
    hidden_layer_mac_if.slave  bus
);

    localparam int AW    = $clog2(2 * N_IN + 2);
    localparam int IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int K_W   = $clog2(2 * N_IN);

    localparam logic [AW-1:0]    B1_ADDR  = AW'(2 * N_IN);
    localparam logic [AW-1:0]    B2_ADDR  = AW'(2 * N_IN + 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_IN - 1);
    localparam logic [K_W-1:0]   K_LAST   = K_W'(2 * N_IN - 1);
    localparam logic [K_W-1:0]   K_SPLIT  = K_W'(N_IN);

    state_t state, state_nxt;

    logic [IDX_W-1:0]         idx;
    logic [K_W-1:0]           k;
    logic signed [DATA_W-1:0] xbuf [N_IN];
    logic signed [DATA_W-1:0] w1   [N_IN];
    logic signed [DATA_W-1:0] w2   [N_IN];
    logic signed [DATA_W-1:0] b1, b2;

    logic                     x_hs, last_x, cfg_ok, mac_en, mac_sel;
    logic [IDX_W-1:0]         lane;
    logic signed [DATA_W-1:0] b1_eff, b2_eff, mac_a, mac_b;
    logic signed [ACC_W-1:0]  acc1, acc2;

    function automatic logic signed [DATA_W-1:0] reduce(input logic signed [ACC_W-1:0] a);
`ifdef HIDDEN_SAT_EN
        if (a > ACC_W'(Q_MAX)) return Q_MAX;
        if (a < ACC_W'(Q_MIN)) return Q_MIN;
        return DATA_W'(a);
`else
        return DATA_W'(a);
`endif
    endfunction

    // x_ready depends on state only, so there is no path from x_valid to x_ready.
    assign bus.x_ready   = (state == LOAD);
    assign bus.out_valid = (state == OUT);
    assign bus.busy      = (state != LOAD);

    assign x_hs   = bus.x_valid && bus.x_ready;
    assign last_x = x_hs && (idx == IDX_LAST);
    assign cfg_ok = bus.cfg_we && (state == LOAD) && (idx == '0);

    // A bias written on the same edge as the frame-closing sample must reach the preload.
    assign b1_eff = (cfg_ok && bus.cfg_addr == B1_ADDR) ? bus.cfg_wdata : b1;
    assign b2_eff = (cfg_ok && bus.cfg_addr == B2_ADDR) ? bus.cfg_wdata : b2;

    assign mac_sel = (k >= K_SPLIT);
    assign lane    = mac_sel ? IDX_W'(k - K_SPLIT) : IDX_W'(k);
    assign mac_a   = xbuf[lane];
    assign mac_b   = mac_sel ? w2[lane] : w1[lane];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= LOAD;
        else        state <= state_nxt;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        mac_en    = 1'b0;
        unique case (state)
            LOAD: if (last_x) state_nxt = MAC;
            MAC: begin
                mac_en = 1'b1;
                if (k == K_LAST) state_nxt = ACT;
            end
            ACT:  state_nxt = OUT;
            OUT:  if (bus.out_ready) state_nxt = LOAD;
            default: state_nxt = LOAD;
        endcase
    end

    // NOTE: coefficient and sample arrays are reset explicitly; a frame after reset must
    // compute from all-zero weights, not from whatever the storage powered up with.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_IN; i++) begin
                w1[i] <= '0;
                w2[i] <= '0;
            end
            b1 <= '0;
            b2 <= '0;
        end else if (cfg_ok) begin
            for (int i = 0; i < N_IN; i++) begin
                if (bus.cfg_addr == AW'(i))        w1[i] <= bus.cfg_wdata;
                if (bus.cfg_addr == AW'(N_IN + i)) w2[i] <= bus.cfg_wdata;
            end
            if (bus.cfg_addr == B1_ADDR) b1 <= bus.cfg_wdata;
            if (bus.cfg_addr == B2_ADDR) b2 <= bus.cfg_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_IN; i++) xbuf[i] <= '0;
            idx      <= '0;
            k        <= '0;
            bus.N1_1 <= '0;
            bus.N1_2 <= '0;
        end else begin
            if (x_hs) begin
                for (int i = 0; i < N_IN; i++) begin
                    if (idx == IDX_W'(i)) xbuf[i] <= bus.x_data;
                end
                idx <= last_x ? '0 : idx + IDX_W'(1);
            end
            if (mac_en) k <= (k == K_LAST) ? '0 : k + K_W'(1);
            if (state == ACT) begin
                bus.N1_1 <= relu(reduce(acc1));
                bus.N1_2 <= relu(reduce(acc2));
            end
        end
    end

    nn_mac_unit #(.ACC_W(ACC_W)) u_mac (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (last_x),
        .load1   (ACC_W'(b1_eff)),
        .load2   (ACC_W'(b2_eff)),
        .en      (mac_en),
        .acc_sel (mac_sel),
        .a       (mac_a),
        .b       (mac_b),
        .acc1    (acc1),
        .acc2    (acc2)
    );

endmodule

// File: tb/tb_hidden_layer_mac.sv
// Self-checking bench for hidden_layer_mac: directed scenarios plus random frames,
// each result compared with an arithmetic model of the two hidden neurons.
module tb_hidden_layer_mac;

    localparam int N_IN = 2;
    localparam int AW   = $clog2(2 * N_IN + 2);
    localparam int LAT  = 2 * N_IN + 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    hidden_layer_mac_if #(.N_IN(N_IN)) bus ();

    hidden_layer_mac #(.N_IN(N_IN), .ACC_W(28)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Model coefficient store, in plain integers.
    int mw1 [N_IN];
    int mw2 [N_IN];
    int mb1, mb2;
    int fx  [N_IN];

    function automatic int sx20(input int v);
        logic [19:0] t;
        t = 20'(v);
        return int'(signed'(t));
    endfunction

    function automatic int neuron(input int xs[N_IN], input int w[N_IN], input int b);
        longint acc, p, r;
        acc = b;
        for (int i = 0; i < N_IN; i++) begin
            p   = longint'(xs[i]) * longint'(w[i]);
            acc = acc + (p >>> 15);
        end
`ifdef HIDDEN_SAT_EN
        if (acc > 524287)       r = 524287;
        else if (acc < -524288) r = -524288;
        else                    r = acc;
`else
        r = acc & 64'hFFFFF;
        if (r >= 524288) r = r - 1048576;
`endif
        return (r < 0) ? 0 : int'(r);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < N_IN; i++) begin
            mw1[i] = 0;
            mw2[i] = 0;
        end
        mb1 = 0;
        mb2 = 0;
    endtask

    task automatic model_write(input int addr, input int data);
        if (addr < N_IN)                mw1[addr] = sx20(data);
        else if (addr < 2 * N_IN)       mw2[addr - N_IN] = sx20(data);
        else if (addr == 2 * N_IN)      mb1 = sx20(data);
        else if (addr == 2 * N_IN + 1)  mb2 = sx20(data);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic cfg_write(input int addr, input int data);
        @(negedge clk);
        bus.cfg_we    = 1'b1;
        bus.cfg_addr  = AW'(addr);
        bus.cfg_wdata = 20'(data);
        @(posedge clk);
        #1 bus.cfg_we = 1'b0;
        model_write(addr, data);
    endtask

    // mode 0: plain frame; 1: cfg write on the first-sample edge (accepted);
    // 2: cfg write after the first sample (ignored).
    task automatic run_frame(input int xs[N_IN], input int mode, input int ca, input int cd,
                             input int hold, input string tag);
        int e1, e2, n, lat;
        if (mode == 1) model_write(ca, cd);
        e1 = neuron(xs, mw1, mb1);
        e2 = neuron(xs, mw2, mb2);
        for (int i = 0; i < N_IN; i++) begin
            @(negedge clk);
            bus.x_valid = 1'b1;
            bus.x_data  = 20'(xs[i]);
            if (i == 0 && mode == 1) begin
                bus.cfg_we    = 1'b1;
                bus.cfg_addr  = AW'(ca);
                bus.cfg_wdata = 20'(cd);
            end
            n = 0;
            while (!bus.x_ready && n < 50) begin
                @(negedge clk);
                n++;
            end
            chk({tag, " x_ready wait"}, (n < 50) ? 1 : 0, 1);
            @(posedge clk);
            #1;
            bus.x_valid = 1'b0;
            bus.cfg_we  = 1'b0;
            if (i == 0 && mode == 2) begin
                @(negedge clk);
                bus.cfg_we    = 1'b1;
                bus.cfg_addr  = AW'(ca);
                bus.cfg_wdata = 20'(cd);
                @(posedge clk);
                #1 bus.cfg_we = 1'b0;
            end
            if (i < N_IN - 1) repeat ($urandom_range(0, 1)) @(posedge clk);
        end
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.out_valid && lat < 40);
        chk({tag, " latency"}, lat, LAT);
        chk({tag, " N1_1"}, int'(bus.N1_1), e1);
        chk({tag, " N1_2"}, int'(bus.N1_2), e2);
        for (int c = 0; c < hold; c++) begin
            @(negedge clk);
            chk({tag, " hold out_valid"}, int'(bus.out_valid), 1);
            chk({tag, " hold x_ready"}, int'(bus.x_ready), 0);
            chk({tag, " hold N1_1"}, int'(bus.N1_1), e1);
            chk({tag, " hold N1_2"}, int'(bus.N1_2), e2);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        @(negedge clk);
        chk({tag, " post out_valid"}, int'(bus.out_valid), 0);
        chk({tag, " post x_ready"}, int'(bus.x_ready), 1);
        chk({tag, " post busy"}, int'(bus.busy), 0);
        chk({tag, " post N1_1 kept"}, int'(bus.N1_1), e1);
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.cfg_we    = 1'b0;
        bus.cfg_addr  = '0;
        bus.cfg_wdata = '0;
        bus.x_valid   = 1'b0;
        bus.x_data    = '0;
        bus.out_ready = 1'b0;
        model_clear();
        repeat (3) @(negedge clk);
        chk("reset out_valid", int'(bus.out_valid), 0);
        chk("reset x_ready", int'(bus.x_ready), 1);
        chk("reset busy", int'(bus.busy), 0);
        chk("reset N1_1", int'(bus.N1_1), 0);
        chk("reset N1_2", int'(bus.N1_2), 0);
        rst_n = 1'b1;
        fx = '{12345, -7777};
        run_frame(fx, 0, 0, 0, 0, "zero_weights");
    endtask

    task automatic test_basic();
        cfg_write(0, 32768);
        cfg_write(1, 16384);
        cfg_write(4, 0);
        fx = '{16384, 16384};
        run_frame(fx, 0, 0, 0, 0, "basic");
        chk("basic N1_1 literal", int'(bus.N1_1), 24576);
    endtask

    task automatic test_relu();
        cfg_write(2, -32768);
        cfg_write(3, 0);
        cfg_write(5, 8192);
        fx = '{16384, 0};
        run_frame(fx, 0, 0, 0, 0, "relu");
        chk("relu N1_2 literal", int'(bus.N1_2), 0);
    endtask

    task automatic test_backpressure();
        fx = '{-20000, 30000};
        run_frame(fx, 0, 0, 0, 5, "backpressure");
    endtask

    task automatic test_overflow();
        cfg_write(0, 524287);
        cfg_write(1, 524287);
        cfg_write(4, 0);
        fx = '{524287, 524287};
        run_frame(fx, 0, 0, 0, 0, "overflow");
`ifdef HIDDEN_SAT_EN
        chk("overflow N1_1 literal", int'(bus.N1_1), 524287);
`else
        chk("overflow N1_1 literal", int'(bus.N1_1), 0);
`endif
    endtask

    task automatic test_cfg_lock();
        cfg_write(0, 32768);
        cfg_write(1, 16384);
        fx = '{16384, 16384};
        run_frame(fx, 2, 0, 0, 0, "cfg_after_first");
        run_frame(fx, 0, 0, 0, 0, "cfg_old_w_kept");
        run_frame(fx, 1, 4, 4096, 0, "cfg_with_first");
        cfg_write(6, 99999);
        cfg_write(7, 12345);
        run_frame(fx, 0, 0, 0, 0, "cfg_bad_addr");
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < N_IN; i++) begin
            @(negedge clk);
            bus.x_valid = 1'b1;
            bus.x_data  = 20'(16384 * (i + 1));
            @(posedge clk);
            #1 bus.x_valid = 1'b0;
        end
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midreset out_valid", int'(bus.out_valid), 0);
        chk("midreset x_ready", int'(bus.x_ready), 1);
        chk("midreset busy", int'(bus.busy), 0);
        chk("midreset N1_1", int'(bus.N1_1), 0);
        chk("midreset N1_2", int'(bus.N1_2), 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        cfg_write(0, 40000);
        cfg_write(2, 10000);
        cfg_write(5, 3000);
        fx = '{50000, -8000};
        run_frame(fx, 0, 0, 0, 0, "after_midreset");
    endtask

    task automatic test_random();
        int lim;
        for (int f = 0; f < 12; f++) begin
            lim = (f % 2 == 0) ? 65536 : 524288;
            for (int a = 0; a < 2 * N_IN + 2; a++)
                cfg_write(a, int'($urandom_range(0, 2 * lim - 1)) - lim);
            for (int i = 0; i < N_IN; i++)
                fx[i] = int'($urandom_range(0, 2 * lim - 1)) - lim;
            run_frame(fx, int'($urandom_range(0, 2)), int'($urandom_range(0, 7)),
                      int'($urandom_range(0, 2 * lim - 1)) - lim,
                      int'($urandom_range(0, 2)), "random");
        end
    endtask

    task automatic test_back_to_back();
        for (int f = 0; f < 3; f++) begin
            fx = '{1000 * (f + 1), -500 * f};
            run_frame(fx, 0, 0, 0, 0, "back_to_back");
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_relu();
        test_backpressure();
        test_overflow();
        test_cfg_lock();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
